operand_fetch_decode: RTL

- Upstream stage of the 16-bit ALU datapath.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes the 3-bit opcode.
- Reads an internal 8x16 register file, drives operands rg1/rg2 and an ALU op to the ALU, then writes the ALU's registered result back.
- Also owns the DPS (display) output and the CLEAR operation.

---
 rtl/operand_fetch_decode_if.sv | 24 ++
 rtl/operand_fetch_decode.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/operand_fetch_decode_if.sv
// Handshake and ALU-facing bus of the operand fetch/decode stage.
// master: upstream instruction source plus the ALU result path.
// slave : the operand_fetch_decode block.
interface operand_fetch_decode_if;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  alu_op;
   logic [15:0] rg1;
   logic [15:0] rg2;
   logic [15:0] resultado;
   logic        dps_valid;
   logic [15:0] dps_data;

   modport master (
      output instr, instr_valid, resultado,
      input  instr_ready, alu_op, rg1, rg2, dps_valid, dps_data
   );

   modport slave (
      input  instr, instr_valid, resultado,
      output instr_ready, alu_op, rg1, rg2, dps_valid, dps_data
   );
endinterface

// File: rtl/operand_fetch_decode.sv
// Operand fetch / decode stage of the 16-bit ALU datapath.
// Captures one instruction at a time, reads the 8x16 register file, presents
// operands to the ALU, waits ALU_LAT cycles and writes the result back.
// Also handles CLEAR (zero a register) and DPS (display a register).
// Optional: define OFD_RETIRE_CNT_EN to add the retired-instruction counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a new instruction
// DECODE | register operands and alu_op from the captured instruction
// EXEC   | wait ALU_LAT cycles for the registered ALU result
// WB     | write result / clear register / drive display, then IDLE
module operand_fetch_decode #(
   parameter int ALU_LAT = 1,
   parameter int NREGS   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   operand_fetch_decode_if.slave  bus,
`ifdef OFD_RETIRE_CNT_EN
   output logic [15:0]            retired,
`endif
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_ADDI  = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_SUBI  = 3'd4;
   localparam logic [2:0] OP_MULT  = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_DPS   = 3'd7;

   // EXEC lasts ALU_LAT cycles: counter is loaded with ALU_LAT-1 and the
   // terminal count (zero) hands over to WB, where resultado is valid.
   localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

   state_t      state;
   logic [15:0] instr_q;
   logic [1:0]  lat_cnt;
   logic [15:0] regs [NREGS];
   logic [2:0]  alu_op_q;
   logic [15:0] rg1_q;
   logic [15:0] rg2_q;
   logic        dps_valid_q;
   logic [15:0] dps_data_q;

   logic [2:0]  opcode;
   logic [2:0]  rd;
   logic [2:0]  rs1;
   logic [2:0]  rs2;
   logic [15:0] imm_sext;

   assign opcode   = instr_q[15:13];
   assign rd       = instr_q[12:10];
   assign rs1      = instr_q[9:7];
   assign rs2      = instr_q[6:4];
   assign imm_sext = {{9{instr_q[6]}}, instr_q[6:0]};

   assign bus.instr_ready = (state == IDLE) && !rst;
   assign bus.alu_op      = alu_op_q;
   assign bus.rg1         = rg1_q;
   assign bus.rg2         = rg2_q;
   assign bus.dps_valid   = dps_valid_q;
   assign bus.dps_data    = dps_data_q;
   assign busy            = (state != IDLE);

   // Sequencer, register file and registered ALU/display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         instr_q     <= '0;
         lat_cnt     <= '0;
         alu_op_q    <= '0;
         rg1_q       <= '0;
         rg2_q       <= '0;
         dps_valid_q <= 1'b0;
         dps_data_q  <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef OFD_RETIRE_CNT_EN
         retired     <= '0;
`endif
      end else begin
         dps_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.instr_valid) begin
                  instr_q <= bus.instr;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               lat_cnt <= LAT_LOAD;
               case (opcode)
                  OP_LOAD: begin
                     alu_op_q <= OP_ADD;
                     rg1_q    <= '0;
                     rg2_q    <= imm_sext;
                  end
                  OP_ADD, OP_SUB, OP_MULT: begin
                     alu_op_q <= opcode;
                     rg1_q    <= regs[rs1];
                     rg2_q    <= regs[rs2];
                  end
                  OP_ADDI: begin
                     alu_op_q <= OP_ADD;
                     rg1_q    <= regs[rs1];
                     rg2_q    <= imm_sext;
                  end
                  OP_SUBI: begin
                     alu_op_q <= OP_SUB;
                     rg1_q    <= regs[rs1];
                     rg2_q    <= imm_sext;
                  end
                  default: ;
               endcase
               state <= (opcode == OP_CLEAR || opcode == OP_DPS) ? WB : EXEC;
            end
            EXEC: begin
               if (lat_cnt == 2'd0) state <= WB;
               else                 lat_cnt <= lat_cnt - 2'd1;
            end
            WB: begin
               case (opcode)
                  OP_CLEAR: regs[rd] <= '0;
                  OP_DPS: begin
                     dps_data_q  <= regs[rs1];
                     dps_valid_q <= 1'b1;
                  end
                  default:  regs[rd] <= bus.resultado;
               endcase
`ifdef OFD_RETIRE_CNT_EN
               retired <= retired + 16'd1;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
